// File: rtl/wb_source_sequencer.sv
// Write-back sequencer: steers the register-file write-data mux and
// issues one register write per request once the chosen source is valid.
module wb_source_sequencer #(
  parameter int MEM_WAIT   = 2,
  parameter int MD_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src,
  input  logic [4:0] req_dst,
  input  logic       md_busy,
  input  logic       md_done,
  output logic [2:0] mux_sel,
  output logic       reg_write,
  output logic [4:0] write_reg,
  output logic       wb_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WAIT_MD,
    WRITE
  } state_t;

  localparam logic [7:0] MEM_LOAD = 8'(MEM_WAIT - 1);
  localparam logic [7:0] MD_LIMIT = 8'(MD_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [4:0] wreg_q, wreg_d;
  logic       rw_q, rw_d;
  logic       err_q, err_d;

  logic       src_direct;
  logic       src_mem;
  logic       src_md;
  logic       src_bad;
  logic [7:0] cnt_inc;

  assign src_direct = (req_src == 3'd0) || (req_src == 3'd4);
  assign src_mem    = (req_src == 3'd1);
  assign src_md     = (req_src == 3'd2) || (req_src == 3'd3);
  assign src_bad    = (req_src > 3'd4);
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wreg_d  = wreg_q;
    rw_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            src_direct: begin
              state_d = WRITE;
              sel_d   = req_src;
              wreg_d  = req_dst;
              rw_d    = (req_dst != 5'd0);
            end
            src_mem: begin
              state_d = WAIT_MEM;
              sel_d   = req_src;
              wreg_d  = req_dst;
              cnt_d   = MEM_LOAD;
            end
            src_md: begin
              state_d = WAIT_MD;
              sel_d   = req_src;
              wreg_d  = req_dst;
              cnt_d   = 8'd0;
            end
            src_bad: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      WAIT_MEM: begin
        if (cnt_q == 8'd0) begin
          state_d = WRITE;
          rw_d    = (wreg_q != 5'd0);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAIT_MD: begin
        // a completion seen on the last allowed cycle beats the timeout
        if (md_done || !md_busy) begin
          state_d = WRITE;
          rw_d    = (wreg_q != 5'd0);
        end else if (cnt_inc == MD_LIMIT) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      wreg_q  <= 5'd0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wreg_q  <= wreg_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign mux_sel   = sel_q;
  assign write_reg = wreg_q;
  assign reg_write = rw_q;
  assign wb_error  = err_q;

endmodule

// File: tb/tb_wb_source_sequencer.sv
// Bench for wb_source_sequencer: deadline-based reference model checked
// every cycle, plus directed scenarios with literal latency expectations.
module tb_wb_source_sequencer;

  localparam int MEM_WAIT   = 2;
  localparam int MD_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_src = 3'd0;
  logic [4:0] req_dst = 5'd0;
  logic       md_busy = 1'b0;
  logic       md_done = 1'b0;
  logic       req_ready;
  logic [2:0] mux_sel;
  logic       reg_write;
  logic [4:0] write_reg;
  logic       wb_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  wb_source_sequencer #(
    .MEM_WAIT(MEM_WAIT),
    .MD_TIMEOUT(MD_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src(req_src),
    .req_dst(req_dst),
    .md_busy(md_busy),
    .md_done(md_done),
    .mux_sel(mux_sel),
    .reg_write(reg_write),
    .write_reg(write_reg),
    .wb_error(wb_error),
    .busy(busy)
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               n, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each accepted request owns a write cycle w,
  // known at acceptance except for HI/LO, which wait on the md unit.
  bit         pend = 1'b0;
  bit         md_wait = 1'b0;
  int         w = -10;
  int         acc = 0;
  logic [2:0] e_sel = 3'd0;
  logic [4:0] e_wreg = 5'd0;
  bit         e_rw = 1'b0;
  bit         e_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    int t;
    if (reset) begin
      pend = 0;
      md_wait = 0;
      w = -10;
      e_sel = 0;
      e_wreg = 0;
      e_rw = 0;
      e_err = 0;
    end else begin
      t = cyc + 1;
      e_err = 0;
      if (pend && t == w + 1) begin
        pend = 0;
      end else if (pend && md_wait) begin
        if (md_done || !md_busy) begin
          w = t;
          md_wait = 0;
        end else if (t - acc == MD_TIMEOUT) begin
          pend = 0;
          md_wait = 0;
          e_err = 1;
        end
      end else if (!pend && req_valid) begin
        if (req_src > 3'd4) begin
          e_err = 1;
        end else begin
          pend = 1;
          acc = t;
          e_sel = req_src;
          e_wreg = req_dst;
          if (req_src == 3'd1) w = t + MEM_WAIT;
          else if (req_src == 3'd2 || req_src == 3'd3) begin
            md_wait = 1;
            w = -10;
          end else w = t;
        end
      end
      e_rw = pend && (t == w) && (e_wreg != 5'd0);
    end
  end

  always @(negedge clk) begin
    chk("req_ready", int'(req_ready), int'(!pend));
    chk("busy", int'(busy), int'(pend));
    chk("reg_write", int'(reg_write), int'(e_rw));
    chk("wb_error", int'(wb_error), int'(e_err));
    chk("mux_sel", int'(mux_sel), int'(e_sel));
    chk("write_reg", int'(write_reg), int'(e_wreg));
  end

  int wr_count = 0;
  int last_wr_cyc = -1;
  int last_wr_sel = -1;
  int err_count = 0;
  int last_err_cyc = -1;
  int busy_cnt = 0;
  int wr_q[$];

  always @(negedge clk) begin
    if (reg_write) begin
      wr_count++;
      last_wr_cyc = cyc;
      last_wr_sel = int'(mux_sel);
      wr_q.push_back(cyc);
    end
    if (wb_error) begin
      err_count++;
      last_err_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  function automatic int wrote_at(input int c);
    foreach (wr_q[i]) if (wr_q[i] == c) return 1;
    return 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns e = cycle index right after the accepting edge
  task automatic req(input logic [2:0] s, input logic [4:0] d,
                     output int e);
    bit r;
    e = -1;
    @(negedge clk);
    #1;
    req_valid = 1'b1;
    req_src = s;
    req_dst = d;
    for (int i = 0; i < 60 && e < 0; i++) begin
      r = req_ready;
      @(negedge clk);
      if (r) e = cyc;
    end
    if (e < 0) chk("accept_timeout", 0, 1);
    #1;
    req_valid = 1'b0;
    req_src = 3'd1;
    req_dst = 5'd31;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, n, ne, nb, dc;
    #1 reset = 1'b1;
    idle(3);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(mux_sel), 0);
    chk("rst_wreg", int'(write_reg), 0);
    chk("rst_rw", int'(reg_write), 0);
    chk("rst_err", int'(wb_error), 0);
    #1 reset = 1'b0;

    n = wr_count;
    req(3'd0, 5'd5, e);
    idle(3);
    chk("alu_lat", last_wr_cyc - e + 1, 1);
    chk("alu_cnt", wr_count - n, 1);
    chk("alu_sel", last_wr_sel, 0);

    req(3'd1, 5'd9, e);
    req(3'd4, 5'd3, e2);
    idle(3);
    chk("mdr_write_at", wrote_at(e + MEM_WAIT), 1);
    chk("b2b_accept_gap", e2 - e, 4);
    chk("shift_lat", last_wr_cyc - e2 + 1, 1);
    chk("shift_sel", last_wr_sel, 4);

    md_busy = 1'b1;
    req(3'd2, 5'd10, e);
    idle(6);
    #1 md_done = 1'b1;
    dc = cyc;
    idle(1);
    #1 md_done = 1'b0;
    idle(2);
    md_busy = 1'b0;
    idle(2);
    chk("md_done_lat", last_wr_cyc - dc, 1);
    chk("md_sel", last_wr_sel, 2);

    req(3'd2, 5'd10, e);
    idle(3);
    chk("md_free_lat", last_wr_cyc - e + 1, 2);

    md_busy = 1'b1;
    n = wr_count;
    ne = err_count;
    req(3'd3, 5'd11, e);
    idle(45);
    chk("to_err_cnt", err_count - ne, 1);
    chk("to_err_at", last_err_cyc - e, MD_TIMEOUT);
    chk("to_no_write", wr_count - n, 0);

    ne = err_count;
    req(3'd3, 5'd12, e);
    idle(39);
    #1 md_done = 1'b1;
    idle(1);
    #1 md_done = 1'b0;
    idle(3);
    md_busy = 1'b0;
    chk("late_done_at", last_wr_cyc - e, MD_TIMEOUT);
    chk("late_done_sel", last_wr_sel, 3);
    chk("late_done_no_err", err_count - ne, 0);

    n = wr_count;
    ne = err_count;
    req(3'd6, 5'd7, e);
    idle(2);
    chk("bad_err_cnt", err_count - ne, 1);
    chk("bad_err_at", last_err_cyc, e);
    chk("bad_no_write", wr_count - n, 0);

    n = wr_count;
    nb = busy_cnt;
    req(3'd0, 5'd0, e);
    idle(2);
    chk("r0_no_write", wr_count - n, 0);
    chk("r0_busy_cycles", busy_cnt - nb, 1);

    n = wr_count;
    req(3'd1, 5'd8, e);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_sel", int'(mux_sel), 0);
    chk("mid_rst_wreg", int'(write_reg), 0);
    chk("mid_rst_rw", int'(reg_write), 0);
    idle(2);
    #1 reset = 1'b0;
    idle(6);
    chk("mid_rst_no_write", wr_count - n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
